// File: rtl/mem_access_stage_pkg.sv
// Shared widths, memory aluop codes and access helpers for the memory-access stage.
// Stands in for the widths and opcodes the core keeps in defines.v.
package mem_access_stage_pkg;

    localparam int REG_BUS      = 32;
    localparam int REG_ADDR_BUS = 5;
    localparam int ALU_OP_BUS   = 8;
    localparam int MEM_ADDR_BUS = 32;

    typedef logic [ALU_OP_BUS-1:0] aluop_t;

    localparam aluop_t EXE_NOP_OP = 8'h00;
    localparam aluop_t EXE_ADD_OP = 8'h20;
    localparam aluop_t EXE_LB_OP  = 8'he0;
    localparam aluop_t EXE_LH_OP  = 8'he1;
    localparam aluop_t EXE_LW_OP  = 8'he3;
    localparam aluop_t EXE_LBU_OP = 8'he4;
    localparam aluop_t EXE_LHU_OP = 8'he5;
    localparam aluop_t EXE_SB_OP  = 8'he8;
    localparam aluop_t EXE_SH_OP  = 8'he9;
    localparam aluop_t EXE_SW_OP  = 8'heb;

    // Everything the bus and write-back need once the stage stops looking at its inputs.
    typedef struct packed {
        aluop_t                  op;
        logic [MEM_ADDR_BUS-1:0] addr;
        logic [3:0]              be;
        logic [REG_BUS-1:0]      wdata;
        logic [REG_ADDR_BUS-1:0] waddr;
    } mem_txn_t;

    function automatic logic is_load(aluop_t op);
        return op inside {EXE_LB_OP, EXE_LH_OP, EXE_LW_OP, EXE_LBU_OP, EXE_LHU_OP};
    endfunction

    function automatic logic is_store(aluop_t op);
        return op inside {EXE_SB_OP, EXE_SH_OP, EXE_SW_OP};
    endfunction

    function automatic logic is_half(aluop_t op);
        return op inside {EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP};
    endfunction

    function automatic logic is_word(aluop_t op);
        return op inside {EXE_LW_OP, EXE_SW_OP};
    endfunction

    function automatic logic misaligned(aluop_t op, logic [1:0] lo);
        return (is_half(op) && lo[0]) || (is_word(op) && (lo != 2'b00));
    endfunction

    function automatic logic [3:0] access_be(aluop_t op, logic [1:0] lo);
        if (is_word(op)) return 4'b1111;
        if (is_half(op)) return lo[1] ? 4'b1100 : 4'b0011;
        return 4'b0001 << lo;
    endfunction

    function automatic logic [REG_BUS-1:0] store_data(aluop_t op, logic [REG_BUS-1:0] rt);
        if (is_word(op)) return rt;
        if (is_half(op)) return {2{rt[15:0]}};
        return {4{rt[7:0]}};
    endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// Data-memory request/grant/rvalid port between the memory-access stage and data memory.
interface mem_access_stage_if;

    logic                                      req;
    logic                                      we;
    logic [mem_access_stage_pkg::MEM_ADDR_BUS-1:0] addr;
    logic [3:0]                                be;
    logic [mem_access_stage_pkg::REG_BUS-1:0]  wdata;
    logic                                      gnt;
    logic                                      rvalid;
    logic [mem_access_stage_pkg::REG_BUS-1:0]  rdata;

    modport master (output req, we, addr, be, wdata, input gnt, rvalid, rdata);
    modport slave  (input req, we, addr, be, wdata, output gnt, rvalid, rdata);

endinterface

// File: rtl/mem_access_stage_load_extract.sv
// Picks the addressed byte/half out of a load word and sign- or zero-extends it.
module mem_access_stage_load_extract
    import mem_access_stage_pkg::*;
(
    input  aluop_t             aluop,
    input  logic [1:0]         addr_lo,
    input  logic [REG_BUS-1:0] rdata,
    output logic [REG_BUS-1:0] data_o
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        case (addr_lo)
            2'd0:    lane_b = rdata[7:0];
            2'd1:    lane_b = rdata[15:8];
            2'd2:    lane_b = rdata[23:16];
            default: lane_b = rdata[31:24];
        endcase
        lane_h = addr_lo[1] ? rdata[31:16] : rdata[15:0];

        case (aluop)
            EXE_LB_OP:  data_o = {{24{lane_b[7]}}, lane_b};
            EXE_LBU_OP: data_o = {24'd0, lane_b};
            EXE_LH_OP:  data_o = {{16{lane_h[15]}}, lane_h};
            EXE_LHU_OP: data_o = {16'd0, lane_h};
            default:    data_o = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// Memory-access stage: runs loads/stores on the data-memory port, registers the MEM/WB
// boundary, and stalls upstream while a transaction is outstanding.
module mem_access_stage
    import mem_access_stage_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    we_i,
    input  logic [REG_ADDR_BUS-1:0] reg_waddr_i,
    input  logic [REG_BUS-1:0]      reg_wdata_i,
    input  aluop_t                  aluop_i,
    input  logic [MEM_ADDR_BUS-1:0] mem_addr_i,
    input  logic [REG_BUS-1:0]      rt_data_i,
    mem_access_stage_if.master      dmem,
    output logic                    stallreq,
    output logic                    misalign_o,
    output logic                    we_o,
    output logic [REG_ADDR_BUS-1:0] reg_waddr_o,
    output logic [REG_BUS-1:0]      reg_wdata_o
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT_RD} state_e;

    state_e                  state_q, state_d;
    mem_txn_t                txn_q, txn_d;
    logic                    wb_we_q, wb_we_d;
    logic [REG_ADDR_BUS-1:0] wb_waddr_q, wb_waddr_d;
    logic [REG_BUS-1:0]      wb_wdata_q, wb_wdata_d;
    logic                    misalign_q, misalign_d;
    logic                    stall_c;
    logic [REG_BUS-1:0]      load_data;

    mem_access_stage_load_extract u_load_extract (
        .aluop   (txn_q.op),
        .addr_lo (txn_q.addr[1:0]),
        .rdata   (dmem.rdata),
        .data_o  (load_data)
    );

    // NOTE: every signal written here gets a default first, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        txn_d      = txn_q;
        wb_we_d    = 1'b0;
        wb_waddr_d = wb_waddr_q;
        wb_wdata_d = wb_wdata_q;
        misalign_d = 1'b0;
        stall_c    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (is_load(aluop_i) || is_store(aluop_i)) begin
                    if (misaligned(aluop_i, mem_addr_i[1:0])) begin
                        misalign_d = 1'b1;
                    end else begin
                        txn_d.op    = aluop_i;
                        txn_d.addr  = mem_addr_i;
                        txn_d.be    = access_be(aluop_i, mem_addr_i[1:0]);
                        txn_d.wdata = store_data(aluop_i, rt_data_i);
                        txn_d.waddr = reg_waddr_i;
                        state_d     = S_REQ;
                        stall_c     = 1'b1;
                    end
                end else begin
                    wb_we_d    = we_i;
                    wb_waddr_d = reg_waddr_i;
                    wb_wdata_d = reg_wdata_i;
                end
            end
            S_REQ: begin
                stall_c = !(is_store(txn_q.op) && dmem.gnt);
                if (dmem.gnt) begin
                    state_d = is_store(txn_q.op) ? S_IDLE : S_WAIT_RD;
                end
            end
            S_WAIT_RD: begin
                stall_c = !dmem.rvalid;
                if (dmem.rvalid) begin
                    wb_we_d    = 1'b1;
                    wb_waddr_d = txn_q.waddr;
                    wb_wdata_d = load_data;
                    state_d    = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Reset wins over the combinational stall as well as over the registered state.
        if (rst) stall_c = 1'b0;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values of its peers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            txn_q      <= '0;
            wb_we_q    <= 1'b0;
            wb_waddr_q <= '0;
            wb_wdata_q <= '0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            txn_q      <= txn_d;
            wb_we_q    <= wb_we_d;
            wb_waddr_q <= wb_waddr_d;
            wb_wdata_q <= wb_wdata_d;
            misalign_q <= misalign_d;
        end
    end

    // Bus outputs come only from flops, so req never follows gnt combinationally.
    assign dmem.req   = (state_q == S_REQ);
    assign dmem.we    = (state_q == S_REQ) && is_store(txn_q.op);
    assign dmem.addr  = {txn_q.addr[MEM_ADDR_BUS-1:2], 2'b00};
    assign dmem.be    = txn_q.be;
    assign dmem.wdata = txn_q.wdata;

    assign stallreq    = stall_c;
    assign misalign_o  = misalign_q;
    assign we_o        = wb_we_q;
    assign reg_waddr_o = wb_waddr_q;
    assign reg_wdata_o = wb_wdata_q;

endmodule
